fpu_mantissa_core: RTL and testbench

- Upstream execute stage of the FPU. Feeds the normalize stage directly.
- Unpacks two IEEE-754 single operands and performs the mantissa operation:
  - add/sub: align, then add or subtract;
  - mul: iterative 24x24 shift-add.
- Emits the unnormalised sign, exponent, 48-bit mantissa and operator code that the normalize stage consumes.
- Valid/ready handshake on both sides; one operation in flight at a time.

---
 rtl/fpu_mantissa_core.sv | 263 ++++++++++++++++++++++++++
 tb/tb_fpu_mantissa_core.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_mantissa_core.sv
// Execute stage: unpacks two IEEE singles, aligns and adds/subtracts or iteratively multiplies mantissas.
// Optional macro FPU_MUL_RADIX4_EN retires two multiplier bits per cycle (12 iterations instead of 24).
module fpu_mantissa_core #(
  parameter int EXP_BIAS    = 127,
  parameter int ALIGN_LIMIT = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [1:0]  in_operator,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [7:0]  out_exponent,
  output logic [47:0] out_mantissa,
  output logic [1:0]  out_operator,
  output logic        out_range_err
);

`ifdef FPU_MUL_RADIX4_EN
  localparam logic [4:0] MUL_LAST = 5'd11;
`else
  localparam logic [4:0] MUL_LAST = 5'd23;
`endif
  localparam logic [7:0]        ALIGN_LIM8 = 8'(ALIGN_LIMIT);
  localparam logic signed [9:0] BIAS10     = 10'(EXP_BIAS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    MUL   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q;
  logic        sa_q, sb_q;
  logic [7:0]  ea_q, eb_q;
  logic [23:0] ma_q, mb_q;
  logic [47:0] acc_q, mcand_q;
  logic [23:0] mplier_q;
  logic [4:0]  cnt_q;
`ifdef FPU_MUL_RADIX4_EN
  logic [47:0] mcand3_q, mcand3_d;
`endif

  logic        in_ready_q, out_valid_q, out_sign_q, out_range_err_q;
  logic [7:0]  out_exponent_q;
  logic [47:0] out_mantissa_q;
  logic [1:0]  out_operator_q;

  logic [23:0] ma_in_s, mb_in_s;
  logic        sb_in_s;
  logic        a_big_s, big_sign_s, sml_sign_s;
  logic [7:0]  big_exp_s, sml_exp_s, diff_s;
  logic [23:0] big_mant_s, sml_mant_s, mb_shift_s;
  logic [24:0] addsub_s;
  logic signed [9:0] mexp_s;
  logic        mzero_s, mrange_s;
  logic [47:0] pp_s, acc_d, mcand_d;
  logic [23:0] mplier_d;

  // Hidden bit is set for any nonzero exponent; exponent zero flushes the operand to zero.
  function automatic logic [23:0] unpack_mant(input logic [30:0] f);
    if (f[30:23] != 8'd0) begin
      unpack_mant = {1'b1, f[22:0]};
    end else begin
      unpack_mant = 24'd0;
    end
  endfunction

  // Unpack, alignment, add/sub and multiplier-step datapath.
  always_comb begin
    ma_in_s = unpack_mant(in_a[30:0]);
    mb_in_s = unpack_mant(in_b[30:0]);
    sb_in_s = in_b[31] ^ (in_operator == 2'b01);

    a_big_s = (ea_q > eb_q) || ((ea_q == eb_q) && (ma_q >= mb_q));
    if (a_big_s) begin
      big_sign_s = sa_q; big_exp_s = ea_q; big_mant_s = ma_q;
      sml_sign_s = sb_q; sml_exp_s = eb_q; sml_mant_s = mb_q;
    end else begin
      big_sign_s = sb_q; big_exp_s = eb_q; big_mant_s = mb_q;
      sml_sign_s = sa_q; sml_exp_s = ea_q; sml_mant_s = ma_q;
    end
    diff_s = big_exp_s - sml_exp_s;
    if (diff_s >= ALIGN_LIM8) begin
      mb_shift_s = 24'd0;
    end else begin
      mb_shift_s = sml_mant_s >> diff_s;
    end

    // After the swap A >= B, so the subtraction never goes negative.
    if (sa_q == sb_q) begin
      addsub_s = {1'b0, ma_q} + {1'b0, mb_q};
    end else begin
      addsub_s = {1'b0, ma_q} - {1'b0, mb_q};
    end

    mexp_s   = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - BIAS10;
    mzero_s  = (ma_q == 24'd0) || (mb_q == 24'd0);
    mrange_s = (mexp_s < 10'sd1) || (mexp_s > 10'sd254);

`ifdef FPU_MUL_RADIX4_EN
    case (mplier_q[1:0])
      2'b00:   pp_s = 48'd0;
      2'b01:   pp_s = mcand_q;
      2'b10:   pp_s = mcand_q << 1;
      2'b11:   pp_s = mcand3_q;
      default: pp_s = 48'd0;
    endcase
    mcand_d  = mcand_q << 2;
    mcand3_d = mcand3_q << 2;
    mplier_d = mplier_q >> 2;
`else
    if (mplier_q[0]) begin
      pp_s = mcand_q;
    end else begin
      pp_s = 48'd0;
    end
    mcand_d  = mcand_q << 1;
    mplier_d = mplier_q >> 1;
`endif
    acc_d = acc_q + pp_s;
  end

  // Operation FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      sa_q            <= 1'b0;
      sb_q            <= 1'b0;
      ea_q            <= 8'd0;
      eb_q            <= 8'd0;
      ma_q            <= 24'd0;
      mb_q            <= 24'd0;
      acc_q           <= 48'd0;
      mcand_q         <= 48'd0;
      mplier_q        <= 24'd0;
      cnt_q           <= 5'd0;
`ifdef FPU_MUL_RADIX4_EN
      mcand3_q        <= 48'd0;
`endif
      in_ready_q      <= 1'b1;
      out_valid_q     <= 1'b0;
      out_sign_q      <= 1'b0;
      out_exponent_q  <= 8'd0;
      out_mantissa_q  <= 48'd0;
      out_operator_q  <= 2'b00;
      out_range_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sa_q       <= in_a[31];
            sb_q       <= sb_in_s;
            ea_q       <= in_a[30:23];
            eb_q       <= in_b[30:23];
            ma_q       <= ma_in_s;
            mb_q       <= mb_in_s;
            acc_q      <= 48'd0;
            cnt_q      <= 5'd0;
            mcand_q    <= {24'd0, ma_in_s};
            mplier_q   <= mb_in_s;
`ifdef FPU_MUL_RADIX4_EN
            mcand3_q   <= {24'd0, ma_in_s} + {23'd0, ma_in_s, 1'b0};
`endif
            in_ready_q <= 1'b0;
            case (in_operator)
              2'b10: state_q <= MUL;
              2'b11: begin
                out_sign_q      <= 1'b0;
                out_exponent_q  <= 8'd0;
                out_mantissa_q  <= 48'd0;
                out_operator_q  <= 2'b11;
                out_range_err_q <= 1'b0;
                state_q         <= DONE;
              end
              default: state_q <= ALIGN;
            endcase
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ALIGN: begin
          sa_q    <= big_sign_s;
          ea_q    <= big_exp_s;
          ma_q    <= big_mant_s;
          sb_q    <= sml_sign_s;
          mb_q    <= mb_shift_s;
          state_q <= ADD;
        end
        ADD: begin
          if (addsub_s == 25'd0) begin
            out_sign_q     <= 1'b0;
            out_exponent_q <= 8'd0;
          end else begin
            out_sign_q     <= sa_q;
            out_exponent_q <= ea_q;
          end
          out_mantissa_q  <= {23'd0, addsub_s};
          out_operator_q  <= 2'b00;
          out_range_err_q <= 1'b0;
          out_valid_q     <= 1'b1;
          state_q         <= DONE;
        end
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
`ifdef FPU_MUL_RADIX4_EN
          mcand3_q <= mcand3_d;
`endif
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == MUL_LAST) begin
            out_sign_q     <= sa_q ^ sb_q;
            out_operator_q <= 2'b10;
            if (mzero_s) begin
              out_mantissa_q  <= 48'd0;
              out_exponent_q  <= 8'd0;
              out_range_err_q <= 1'b0;
            end else begin
              out_mantissa_q  <= acc_d;
              out_exponent_q  <= mexp_s[7:0];
              out_range_err_q <= mrange_s;
            end
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            state_q <= MUL;
          end
        end
        DONE: begin
          // Divide enters here with out_valid low; it rises one edge later.
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_sign      = out_sign_q;
  assign out_exponent  = out_exponent_q;
  assign out_mantissa  = out_mantissa_q;
  assign out_operator  = out_operator_q;
  assign out_range_err = out_range_err_q;

endmodule

// File: tb/tb_fpu_mantissa_core.sv
// Scoreboard bench for fpu_mantissa_core: expected results queued at stimulus, compared on out_valid.
`timescale 1ns/1ps
module tb_fpu_mantissa_core;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_operator, out_operator;
  logic        out_sign, out_range_err;
  logic [7:0]  out_exponent;
  logic [47:0] out_mantissa;

`ifdef FPU_MUL_RADIX4_EN
  localparam int MUL_LAT = 12;
`else
  localparam int MUL_LAT = 24;
`endif

  typedef struct {
    logic        sign;
    logic [7:0]  expo;
    logic [47:0] mant;
    logic [1:0]  op;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  fpu_mantissa_core dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_operator(in_operator),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exponent(out_exponent), .out_mantissa(out_mantissa),
    .out_operator(out_operator), .out_range_err(out_range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  function automatic exp_t mk(input logic s, input logic [7:0] e, input logic [47:0] m,
                              input logic [1:0] op, input logic err, input int lat);
    exp_t r;
    r.sign = s; r.expo = e; r.mant = m; r.op = op; r.err = err; r.lat = lat;
    return r;
  endfunction

  // Reference product model: plain multiply of unpacked mantissas.
  function automatic exp_t mul_model(input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [23:0] ma, mb;
    int          e;
    ma = (a[30:23] != 8'd0) ? {1'b1, a[22:0]} : 24'd0;
    mb = (b[30:23] != 8'd0) ? {1'b1, b[22:0]} : 24'd0;
    r.sign = a[31] ^ b[31];
    r.op   = 2'b10;
    r.lat  = MUL_LAT;
    if (ma == 24'd0 || mb == 24'd0) begin
      r.mant = 48'd0; r.expo = 8'd0; r.err = 1'b0;
    end else begin
      r.mant = 48'(ma) * 48'(mb);
      e      = int'(a[30:23]) + int'(b[30:23]) - 127;
      r.err  = (e < 1) || (e > 254);
      r.expo = 8'(e);
    end
    return r;
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input exp_t e);
    int t;
    t = 0;
    in_a = a; in_b = b; in_operator = op; in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("in_ready_idle", 64'(in_ready), 64'(1));
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic pop_compare(input int lat);
    exp_t e;
    check("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("out_valid", 64'(out_valid), 64'(1));
      check("latency", 64'(lat), 64'(e.lat));
      check("mantissa", 64'(out_mantissa), 64'(e.mant));
      check("exponent", 64'(out_exponent), 64'(e.expo));
      check("sign", 64'(out_sign), 64'(e.sign));
      check("operator", 64'(out_operator), 64'(e.op));
      check("range_err", 64'(out_range_err), 64'(e.err));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_drop", 64'(out_valid), 64'(0));
    check("in_ready_back", 64'(in_ready), 64'(1));
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op, input exp_t e);
    int lat;
    start_op(a, b, op, e);
    wait_result(lat);
    pop_compare(lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 32'd0; in_b = 32'd0; in_operator = 2'b00;
    #1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_mant", 64'(out_mantissa), 64'(0));
    check("rst_exp", 64'(out_exponent), 64'(0));
    check("rst_op", 64'(out_operator), 64'(0));
    check("rst_err", 64'(out_range_err), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run_op(32'h3F800000, 32'h3F800000, 2'b00, mk(1'b0, 8'h7F, 48'h000001000000, 2'b00, 1'b0, 2));
    run_op(32'h40400000, 32'h3F800000, 2'b01, mk(1'b0, 8'h80, 48'h000000800000, 2'b00, 1'b0, 2));
    run_op(32'h3F800000, 32'h3F800000, 2'b01, mk(1'b0, 8'h00, 48'h0,            2'b00, 1'b0, 2));
    run_op(32'h3F800000, 32'h40400000, 2'b01, mk(1'b1, 8'h80, 48'h000000800000, 2'b00, 1'b0, 2));
    run_op(32'h4E800000, 32'h3F800000, 2'b00, mk(1'b0, 8'h9D, 48'h000000800000, 2'b00, 1'b0, 2));
    run_op(32'h3F800000, 32'h4E800000, 2'b00, mk(1'b0, 8'h9D, 48'h000000800000, 2'b00, 1'b0, 2));
    run_op(32'h3FC00000, 32'h40000000, 2'b10, mk(1'b0, 8'h80, 48'h600000000000, 2'b10, 1'b0, MUL_LAT));
    run_op(32'hC0000000, 32'h40400000, 2'b10, mk(1'b1, 8'h81, 48'h600000000000, 2'b10, 1'b0, MUL_LAT));
    run_op(32'h00800000, 32'h00800000, 2'b10, mk(1'b0, 8'h83, 48'h400000000000, 2'b10, 1'b1, MUL_LAT));
    run_op(32'h00000000, 32'h3F800000, 2'b10, mk(1'b0, 8'h00, 48'h0,            2'b10, 1'b0, MUL_LAT));
    run_op(32'hC0000000, 32'h3F800000, 2'b11, mk(1'b0, 8'h00, 48'h0,            2'b11, 1'b0, 1));
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      run_op(ra, rb, 2'b10, mul_model(ra, rb));
    end

    // Backpressure: result must hold while a competing request is ignored.
    start_op(32'h3F800000, 32'h3F800000, 2'b00, mk(1'b0, 8'h7F, 48'h000001000000, 2'b00, 1'b0, 2));
    wait_result(lat);
    in_a = 32'h40000000; in_b = 32'h40000000; in_operator = 2'b10; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 64'(out_valid), 64'(1));
      check("bp_mant", 64'(out_mantissa), 64'h000001000000);
      check("bp_in_ready", 64'(in_ready), 64'(0));
    end
    pop_compare(lat);
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("bp_ignored_valid", 64'(out_valid), 64'(0));
    check("bp_idle", 64'(in_ready), 64'(1));

    // Reset in the middle of a multiply.
    start_op(32'h3FC00000, 32'h40000000, 2'b10, mk(1'b0, 8'h80, 48'h600000000000, 2'b10, 1'b0, MUL_LAT));
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_mant", 64'(out_mantissa), 64'(0));
    check("mid_rst_exp", 64'(out_exponent), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    void'(sb_q.pop_front());
    @(negedge clk); rst = 1'b0;
    repeat (30) @(posedge clk); #1;
    check("post_rst_no_valid", 64'(out_valid), 64'(0));
    run_op(32'h3F800000, 32'h3F800000, 2'b10, mk(1'b0, 8'h7F, 48'h400000000000, 2'b10, 1'b0, MUL_LAT));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
